// File: rtl/shift_unit.sv
// Multi-cycle A / A:Q shifter for the IAS datapath.
// Shifts one position per clock under a start/busy/done handshake.
module shift_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             ld,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic             start,
    input  logic             dir,
    input  logic             arith,
    input  logic             pair,
    input  logic [CNT_W-1:0] amount,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] q_out,
    output logic             sh_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, q_q;
    logic [WIDTH-1:0]   a_sh, q_sh;
    logic               sh_q, sh_sh;
    logic [CNT_W-1:0]   cnt_q;
    logic               dir_q, arith_q, pair_q;
    logic               go;

    // ld has priority over start in IDLE.
    assign go = (state_q == StIdle) && start && !ld;

    // Next-state logic for the IDLE -> SHIFT -> DONE sequence.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (go) state_d = (amount == '0) ? StDone : StShift;
            StShift: if (cnt_q == CNT_W'(1)) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // One-position shift of A (or A:Q) using the latched mode.
    always_comb begin
        a_sh  = a_q;
        q_sh  = q_q;
        sh_sh = sh_q;
        if (!dir_q) begin
            a_sh  = {a_q[WIDTH-2:0], pair_q & q_q[WIDTH-1]};
            if (pair_q) q_sh = {q_q[WIDTH-2:0], 1'b0};
            sh_sh = a_q[WIDTH-1];
        end else begin
            a_sh = {arith_q & a_q[WIDTH-1], a_q[WIDTH-1:1]};
            if (pair_q) begin
                q_sh  = {a_q[0], q_q[WIDTH-1:1]};
                sh_sh = q_q[0];
            end else begin
                sh_sh = a_q[0];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // A/Q/sh_out: load in IDLE, shift in SHIFT, otherwise hold.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            a_q  <= '0;
            q_q  <= '0;
            sh_q <= 1'b0;
        end else if (state_q == StIdle && ld) begin
            a_q <= a_in;
            q_q <= q_in;
        end else if (state_q == StShift) begin
            a_q  <= a_sh;
            q_q  <= q_sh;
            sh_q <= sh_sh;
        end
    end

    // Mode latch and remaining-shift counter.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            arith_q <= 1'b0;
            pair_q  <= 1'b0;
        end else if (go) begin
            cnt_q   <= amount;
            dir_q   <= dir;
            arith_q <= arith;
            pair_q  <= pair;
        end else if (state_q == StShift) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign a_out  = a_q;
    assign q_out  = q_q;
    assign sh_out = sh_q;
    assign busy   = (state_q == StShift);
    assign done   = (state_q == StDone);

endmodule

// File: tb/tb_shift_unit.sv
// Self-checking bench for shift_unit (WIDTH=8, CNT_W=4).
module tb_shift_unit;

    logic       clk = 1'b0;
    logic       rst_b = 1'b1;
    logic       ld = 1'b0, start = 1'b0, dir = 1'b0, arith = 1'b0, pair = 1'b0;
    logic [7:0] a_in = '0, q_in = '0;
    logic [3:0] amount = '0;
    logic [7:0] a_out, q_out;
    logic       sh_out, busy, done;

    int vec = 0;
    int err = 0;
    bit chk_en = 1'b0;

    shift_unit #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst_b(rst_b), .ld(ld), .a_in(a_in), .q_in(q_in),
        .start(start), .dir(dir), .arith(arith), .pair(pair), .amount(amount),
        .a_out(a_out), .q_out(q_out), .sh_out(sh_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Result of shifting (a,q) by k places as one word: returns {a, q, sh}.
    function automatic logic [16:0] shf(input logic [7:0] a, input logic [7:0] q,
                                        input logic sh, input logic d, input logic ar,
                                        input logic pr, input int k);
        logic [15:0]        w, r;
        logic signed [15:0] sw, swr;
        logic signed [7:0]  sa, sar;
        int                 width;
        logic               s;
        if (k == 0) return {a, q, sh};
        width = pr ? 16 : 8;
        w = pr ? {a, q} : {8'h00, a};
        if (d) begin
            if (pr) begin
                if (ar) begin sw = w; swr = sw >>> k; r = swr; end
                else r = w >> k;
            end else begin
                if (ar) begin sa = a; sar = sa >>> k; r = {8'h00, sar}; end
                else r = {8'h00, a >> k};
            end
            s = (k - 1 < width) ? w[k-1] : (ar & a[7]);
        end else begin
            r = pr ? (w << k) : {8'h00, a << k};
            s = (k <= width) ? w[width-k] : 1'b0;
        end
        return pr ? {r[15:8], r[7:0], s} : {r[7:0], q, s};
    endfunction

    // Reference model: phase 0 idle, 1 shifting, 2 done.
    int         m_ph, m_k, m_n;
    logic [7:0] m_a, m_q, m_a0, m_q0;
    logic       m_sh, m_sh0, m_dir, m_ar, m_pr;
    logic [16:0] nxt;
    assign nxt = shf(m_a0, m_q0, m_sh0, m_dir, m_ar, m_pr, m_k + 1);

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            m_ph <= 0; m_k <= 0; m_n <= 0;
            m_a <= '0; m_q <= '0; m_sh <= 1'b0;
            m_a0 <= '0; m_q0 <= '0; m_sh0 <= 1'b0;
            m_dir <= 1'b0; m_ar <= 1'b0; m_pr <= 1'b0;
        end else begin
            case (m_ph)
                0: begin
                    if (ld) begin
                        m_a <= a_in; m_q <= q_in;
                    end else if (start) begin
                        m_a0 <= m_a; m_q0 <= m_q; m_sh0 <= m_sh;
                        m_dir <= dir; m_ar <= arith; m_pr <= pair;
                        m_n <= int'(amount); m_k <= 0;
                        m_ph <= (amount == 0) ? 2 : 1;
                    end
                end
                1: begin
                    m_a <= nxt[16:9]; m_q <= nxt[8:1]; m_sh <= nxt[0];
                    m_k <= m_k + 1;
                    if (m_k + 1 == m_n) m_ph <= 2;
                end
                default: m_ph <= 0;
            endcase
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc a_out", a_out, m_a);
            chk("cyc q_out", q_out, m_q);
            chk("cyc sh_out", sh_out, m_sh);
            chk("cyc busy", busy, m_ph == 1);
            chk("cyc done", done, m_ph == 2);
        end
    end

    task automatic do_ld(input logic [7:0] a, input logic [7:0] q);
        @(negedge clk); ld = 1'b1; a_in = a; q_in = q;
        @(negedge clk); ld = 1'b0;
    endtask

    // Start a shift, scramble mode inputs afterwards, wait (bounded) for done.
    task automatic run(input logic d, input logic ar, input logic pr, input logic [3:0] n,
                       input bit disturb, output int cyc, output int nbusy);
        @(negedge clk); dir = d; arith = ar; pair = pr; amount = n; start = 1'b1;
        cyc = 0; nbusy = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            cyc = i; start = 1'b0; ld = 1'b0;
            dir = ~d; arith = ~ar; pair = ~pr; amount = ~n;
            if (busy) nbusy++;
            if (disturb && i == 2) begin
                ld = 1'b1; start = 1'b1; a_in = 8'hFF; q_in = 8'hFF;
            end
            if (done) break;
        end
        ld = 1'b0; start = 1'b0;
    endtask

    task automatic chk_res(input string nm, input int cyc, input int nb, input int n,
                           input logic [7:0] a, input logic [7:0] q, input logic s);
        chk({nm, " latency"}, cyc, n + 1);
        chk({nm, " busy cycles"}, nb, n);
        chk({nm, " a"}, a_out, a);
        chk({nm, " q"}, q_out, q);
        chk({nm, " sh"}, sh_out, s);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc, nb;
        // Asynchronous reset without a clock edge.
        #3 rst_b = 1'b0;
        #1;
        chk("rst a", a_out, 8'h00); chk("rst q", q_out, 8'h00);
        chk("rst sh", sh_out, 1'b0); chk("rst busy", busy, 1'b0); chk("rst done", done, 1'b0);
        chk_en = 1'b1;
        @(negedge clk); rst_b = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle a", a_out, 8'h00); chk("idle busy", busy, 1'b0); chk("idle done", done, 1'b0);

        do_ld(8'b1001_0110, 8'h5A);
        run(1'b0, 1'b0, 1'b0, 4'd3, 1'b0, cyc, nb);
        chk_res("left3", cyc, nb, 3, 8'b1011_0000, 8'h5A, 1'b0);

        do_ld(8'h81, 8'h00);
        run(1'b1, 1'b1, 1'b1, 4'd2, 1'b0, cyc, nb);
        chk_res("pair asr2", cyc, nb, 2, 8'hE0, 8'h40, 1'b0);

        do_ld(8'h01, 8'h80);
        run(1'b0, 1'b0, 1'b1, 4'd1, 1'b0, cyc, nb);
        chk_res("pair lsl1", cyc, nb, 1, 8'h03, 8'h00, 1'b0);

        do_ld(8'hFF, 8'h3C);
        run(1'b1, 1'b0, 1'b0, 4'd15, 1'b0, cyc, nb);
        chk_res("lsr15", cyc, nb, 15, 8'h00, 8'h3C, 1'b0);

        run(1'b1, 1'b1, 1'b1, 4'd0, 1'b0, cyc, nb);
        chk_res("zero amt", cyc, nb, 0, 8'h00, 8'h3C, 1'b0);

        do_ld(8'h2D, 8'h77);
        run(1'b0, 1'b0, 1'b0, 4'd5, 1'b1, cyc, nb);
        chk_res("disturbed lsl5", cyc, nb, 5, 8'hA0, 8'h77, 1'b1);

        // ld and start together: load only.
        @(negedge clk); ld = 1'b1; start = 1'b1; a_in = 8'h12; q_in = 8'h34; amount = 4'd3;
        @(negedge clk); ld = 1'b0; start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("ld+start busy", busy, 1'b0);
        end
        chk("ld+start a", a_out, 8'h12); chk("ld+start q", q_out, 8'h34);

        // Reset in the middle of a 10-position shift.
        do_ld(8'h0F, 8'hF0);
        @(negedge clk); dir = 1'b1; arith = 1'b0; pair = 1'b1; amount = 4'd10; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid busy", busy, 1'b1);
        #2 rst_b = 1'b0;
        #1;
        chk("midrst a", a_out, 8'h00); chk("midrst q", q_out, 8'h00);
        chk("midrst sh", sh_out, 1'b0); chk("midrst busy", busy, 1'b0);
        chk("midrst done", done, 1'b0);
        @(negedge clk); rst_b = 1'b1;
        do_ld(8'hC3, 8'h3C);
        run(1'b0, 1'b0, 1'b1, 4'd2, 1'b0, cyc, nb);
        chk_res("post-rst lsl2", cyc, nb, 2, 8'h0C, 8'hF0, 1'b1);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
